// File: rtl/univ_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_pkg
// Description : Shared types for the universal shift register: the parallel
//               mode encodings, the burst FSM state type and a helper that
//               sizes the burst bit counter.
// Revision    : 1.0 - initial release
// ============================================================================
package univ_shift_pkg;

  // Operating mode presented on the 2-bit mode port while idle.
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  // Burst FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Counter width able to hold the value WIDTH itself (a full burst length).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : univ_shift_pkg
`default_nettype wire

// File: rtl/bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : bit_counter
// Description : Burst bit counter. Loads the burst length WIDTH, counts down
//               by one on each qualified decrement and saturates at zero so
//               it can never wrap.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-low reset (clears count)
//               load   - load count with WIDTH (priority over dec)
//               dec    - decrement by one when nonzero
//               cnt    - current count
//               zero   - count equals zero
// Revision    : 1.0 - initial release
// ============================================================================
module bit_counter
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load,
  input  logic                        dec,
  output logic [cnt_width(WIDTH)-1:0] cnt,
  output logic                        zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_load_val = CW'(WIDTH);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= c_load_val;
    end else if (dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);

endmodule : bit_counter
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register with hold / shift-right /
//               shift-left / parallel-load modes, optional rotate behaviour,
//               and a serial burst engine that loads a word and shifts it out
//               LSB first on ser_out_r, followed by a one-cycle done pulse.
// Ports       : clk       - clock, rising edge
//               reset     - asynchronous active-low reset
//               enable    - advance qualifier; 0 freezes all state
//               mode      - 00 HOLD, 01 SHR, 10 SHL, 11 LOAD (idle only)
//               sin       - serial fill bit (ignored when ROTATE=1)
//               data      - parallel load / burst source word
//               start     - burst request, honoured in IDLE only
//               out       - register contents
//               ser_out_r - out[0]
//               ser_out_l - out[WIDTH-1]
//               busy      - burst in progress (state SHIFT)
//               done      - one-cycle burst completion pulse (state DONE)
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int ROTATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             ser_out_r,
  output logic             ser_out_l,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] w_out_next;
  logic             r_busy;
  logic             r_done;

  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CW-1:0]    w_cnt;
  logic             w_cnt_zero;
  logic             w_cnt_last;

  logic             w_shr_fill;
  logic             w_shl_fill;
  logic [WIDTH-1:0] w_shr_val;
  logic [WIDTH-1:0] w_shl_val;

  // --------------------------------------------------------------------------
  // Fill bits: rotate wraps the opposite end around, otherwise sin is used.
  // --------------------------------------------------------------------------
  if (ROTATE != 0) begin : g_rotate
    assign w_shr_fill = r_out[0];
    assign w_shl_fill = r_out[WIDTH-1];
  end else begin : g_serial
    assign w_shr_fill = sin;
    assign w_shl_fill = sin;
  end

  assign w_shr_val = {w_shr_fill, r_out[WIDTH-1:1]};
  assign w_shl_val = {r_out[WIDTH-2:0], w_shl_fill};

  // --------------------------------------------------------------------------
  // Burst length counter
  // --------------------------------------------------------------------------
  bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .load  (w_cnt_load),
    .dec   (w_cnt_dec),
    .cnt   (w_cnt),
    .zero  (w_cnt_zero)
  );

  assign w_cnt_last = (w_cnt == CW'(1));

  // --------------------------------------------------------------------------
  // Next-state / datapath logic. With enable low every next value equals the
  // current one, so state, data and a pending done pulse are all held.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_out_next   = r_out;
    w_cnt_load   = 1'b0;
    w_cnt_dec    = 1'b0;

    if (enable) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // A burst request outranks whatever mode is presented.
            w_out_next   = data;
            w_cnt_load   = 1'b1;
            w_state_next = ST_SHIFT;
          end else begin
            case (mode_e'(mode))
              MODE_HOLD: w_out_next = r_out;
              MODE_SHR:  w_out_next = w_shr_val;
              MODE_SHL:  w_out_next = w_shl_val;
              MODE_LOAD: w_out_next = data;
              default:   w_out_next = r_out;
            endcase
          end
        end

        ST_SHIFT: begin
          w_out_next = w_shr_val;
          w_cnt_dec  = 1'b1;
          // The zero check only guards against an impossible empty burst.
          if (w_cnt_last || w_cnt_zero) begin
            w_state_next = ST_DONE;
          end
        end

        ST_DONE: begin
          w_state_next = ST_IDLE;
        end

        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers. busy/done are flopped from the next state so they are
  // glitch-free and mutually exclusive.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_out   <= w_out_next;
      r_busy  <= (w_state_next == ST_SHIFT);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign out       = r_out;
  assign ser_out_r = r_out[0];
  assign ser_out_l = r_out[WIDTH-1];
  assign busy      = r_busy;
  assign done      = r_done;

endmodule : univ_shift_reg
`default_nettype wire
